debounce_multi_press: RTL and testbench

- Parametrised N-channel successor to the single-button debouncer.
- Synchronises raw push-button/switch inputs and debounces them on a shared slow sample tick.
- Classifies each press as short or long (hold threshold in sample ticks); long presses can optionally auto-repeat.
- Sits between the board buttons and the FSM/game-logic blocks, replacing the per-button debounce and mode-selected long-wait logic.

---
 rtl/debounce_multi_press.sv | 182 ++++++++++++++++++
 tb/tb_debounce_multi_press.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi_press.sv
// N-channel push-button debouncer with short/long press classification.
// Optional auto-repeat on long presses is built when DEBOUNCE_REPEAT_EN is defined.
module debounce_multi_press #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned DB_TICKS     = 20,
    parameter int unsigned LONG_TICKS   = 5000,
    parameter int unsigned REPEAT_TICKS = 250
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] press_tick,
    output logic [N_CH-1:0] release_tick,
    output logic [N_CH-1:0] short_tick,
    output logic [N_CH-1:0] long_tick,
    output logic [N_CH-1:0] is_long,
    output logic [N_CH-1:0] repeat_tick
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DB_TICKS + 1);
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);
    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_TICKS - 1);
    localparam logic [DW-1:0] D_ONE    = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

    if (N_CH < 1 || TICK_DIV < 2 || DB_TICKS < 2 || LONG_TICKS <= DB_TICKS || REPEAT_TICKS < 1) begin : g_param_check
        $error("debounce_multi_press: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, WAIT1, PRESSED, WAIT0} state_t;

    logic [N_CH-1:0] sync1, s;
    logic [PW-1:0]   ps_cnt;
    logic            sample_en;
    state_t          state    [N_CH];
    logic [DW-1:0]   dcnt     [N_CH];
    logic [HW-1:0]   hcnt     [N_CH];
    logic [HW-1:0]   hold_inc [N_CH];
    logic [N_CH-1:0] long_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            s      <= '0;
            ps_cnt <= '0;
        end else begin
            sync1  <= sw;
            s      <= sync1;
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
        end
    end

    assign sample_en = (ps_cnt == PS_LAST);

    // db_level is high exactly in PRESSED/WAIT0, so it doubles as the hold-phase qualifier.
    always_comb begin
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            hold_inc[ch] = (hcnt[ch] == HOLD_MAX) ? hcnt[ch] : hcnt[ch] + 1'b1;
            long_hit[ch] = db_level[ch] && !is_long[ch] && (hold_inc[ch] == HOLD_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state[ch] <= IDLE;
                dcnt[ch]  <= '0;
                hcnt[ch]  <= '0;
            end
            db_level     <= '0;
            press_tick   <= '0;
            release_tick <= '0;
            short_tick   <= '0;
            long_tick    <= '0;
            is_long      <= '0;
        end else begin
            press_tick   <= '0;
            release_tick <= '0;
            short_tick   <= '0;
            long_tick    <= '0;
            if (sample_en) begin
                for (int unsigned ch = 0; ch < N_CH; ch++) begin
                    if (db_level[ch]) begin
                        hcnt[ch] <= hold_inc[ch];
                        if (long_hit[ch]) begin
                            long_tick[ch] <= 1'b1;
                            is_long[ch]   <= 1'b1;
                        end
                    end
                    case (state[ch])
                        IDLE: begin
                            if (s[ch]) begin
                                state[ch] <= WAIT1;
                                dcnt[ch]  <= D_ONE;
                            end
                        end
                        WAIT1: begin
                            if (!s[ch]) begin
                                state[ch] <= IDLE;
                                dcnt[ch]  <= '0;
                            end else if (dcnt[ch] == DB_LAST) begin
                                state[ch]      <= PRESSED;
                                dcnt[ch]       <= '0;
                                hcnt[ch]       <= '0;
                                is_long[ch]    <= 1'b0;
                                db_level[ch]   <= 1'b1;
                                press_tick[ch] <= 1'b1;
                            end else begin
                                dcnt[ch] <= dcnt[ch] + 1'b1;
                            end
                        end
                        PRESSED: begin
                            if (!s[ch]) begin
                                state[ch] <= WAIT0;
                                dcnt[ch]  <= D_ONE;
                            end
                        end
                        WAIT0: begin
                            if (s[ch]) begin
                                state[ch] <= PRESSED;
                                dcnt[ch]  <= '0;
                            end else if (dcnt[ch] == DB_LAST) begin
                                // A long threshold hit on this same sample suppresses short_tick.
                                state[ch]        <= IDLE;
                                dcnt[ch]         <= '0;
                                hcnt[ch]         <= '0;
                                is_long[ch]      <= 1'b0;
                                db_level[ch]     <= 1'b0;
                                release_tick[ch] <= 1'b1;
                                short_tick[ch]   <= !(is_long[ch] || long_hit[ch]);
                            end else begin
                                dcnt[ch] <= dcnt[ch] + 1'b1;
                            end
                        end
                        default: begin
                            state[ch] <= IDLE;
                            dcnt[ch]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] RPT_PRE = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0] rcnt [N_CH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                rcnt[ch] <= '0;
            end
            repeat_tick <= '0;
        end else begin
            repeat_tick <= '0;
            if (sample_en) begin
                for (int unsigned ch = 0; ch < N_CH; ch++) begin
                    if (long_hit[ch]) begin
                        rcnt[ch] <= '0;
                    end else if (db_level[ch] && is_long[ch]) begin
                        if (rcnt[ch] == RPT_PRE) begin
                            rcnt[ch]        <= '0;
                            repeat_tick[ch] <= 1'b1;
                        end else begin
                            rcnt[ch] <= rcnt[ch] + 1'b1;
                        end
                    end
                end
            end
        end
    end
`else
    assign repeat_tick = '0;
`endif

endmodule

// File: tb/tb_debounce_multi_press.sv
// Scoreboard bench for debounce_multi_press: run-length reference model feeds an
// expected-pulse queue; a negedge monitor pops and compares. Honours DEBOUNCE_REPEAT_EN.
module tb_debounce_multi_press;
    localparam int N_CH         = 4;
    localparam int TICK_DIV     = 4;
    localparam int DB_TICKS     = 3;
    localparam int LONG_TICKS   = 10;
    localparam int REPEAT_TICKS = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] sw = '1;
    logic [N_CH-1:0] db_level, press_tick, release_tick, short_tick, long_tick, is_long, repeat_tick;

    debounce_multi_press #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS),
        .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .sw(sw), .db_level(db_level),
        .press_tick(press_tick), .release_tick(release_tick), .short_tick(short_tick),
        .long_tick(long_tick), .is_long(is_long), .repeat_tick(repeat_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic [N_CH-1:0] pr, rl, sh, lg, rp;
    } ev_t;

    ev_t q[$];
    int  edge_no = 0;
    int  checks = 0, passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, got, exp, edge_no);
    endtask

    // Reference model: a level flips after DB_TICKS consecutive opposite samples;
    // hold is the number of samples seen at level 1 since the press was accepted.
    int              m_ps = 0;
    logic [N_CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_long = '0;
    int              run  [N_CH];
    int              hold [N_CH];

    initial begin
        ev_t ev;
        forever begin
            @(posedge clk);
            edge_no++;
            if (reset) begin
                m_ps = 0; m_s1 = '0; m_s2 = '0; m_lvl = '0; m_long = '0;
                for (int ch = 0; ch < N_CH; ch++) begin run[ch] = 0; hold[ch] = 0; end
            end else begin
                if (m_ps == TICK_DIV - 1) begin
                    ev.cyc = edge_no; ev.pr = '0; ev.rl = '0; ev.sh = '0; ev.lg = '0; ev.rp = '0;
                    for (int ch = 0; ch < N_CH; ch++) begin
                        if (!m_lvl[ch]) begin
                            run[ch] = m_s2[ch] ? run[ch] + 1 : 0;
                            if (run[ch] == DB_TICKS) begin
                                m_lvl[ch] = 1'b1; run[ch] = 0; hold[ch] = 0; ev.pr[ch] = 1'b1;
                            end
                        end else begin
                            hold[ch]++;
                            if (hold[ch] == LONG_TICKS) begin ev.lg[ch] = 1'b1; m_long[ch] = 1'b1; end
`ifdef DEBOUNCE_REPEAT_EN
                            if (hold[ch] > LONG_TICKS && (hold[ch] - LONG_TICKS) % REPEAT_TICKS == 0)
                                ev.rp[ch] = 1'b1;
`endif
                            run[ch] = !m_s2[ch] ? run[ch] + 1 : 0;
                            if (run[ch] == DB_TICKS) begin
                                m_lvl[ch] = 1'b0; run[ch] = 0; ev.rl[ch] = 1'b1;
                                ev.sh[ch] = !m_long[ch]; m_long[ch] = 1'b0;
                            end
                        end
                    end
                    if (|{ev.pr, ev.rl, ev.sh, ev.lg, ev.rp}) q.push_back(ev);
                end
                m_ps = (m_ps == TICK_DIV - 1) ? 0 : m_ps + 1;
                m_s2 = m_s1;
                m_s1 = sw;
            end
        end
    end

    // Monitor: observed pulse bookkeeping for directed checks plus scoreboard compare.
    int              obs_press [N_CH], obs_rel [N_CH], obs_short [N_CH], obs_long [N_CH];
    int              press_cyc [N_CH], rel_cyc [N_CH];
    logic [N_CH-1:0] last_press_vec = '0;

    initial begin
        ev_t ev;
        for (int ch = 0; ch < N_CH; ch++) begin
            obs_press[ch] = 0; obs_rel[ch] = 0; obs_short[ch] = 0; obs_long[ch] = 0;
            press_cyc[ch] = 0; rel_cyc[ch] = 0;
        end
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].cyc == edge_no) begin
                ev = q.pop_front();
                check("press_tick", press_tick, ev.pr);
                check("release_tick", release_tick, ev.rl);
                check("short_tick", short_tick, ev.sh);
                check("long_tick", long_tick, ev.lg);
                check("repeat_tick", repeat_tick, ev.rp);
            end else begin
                check("no_pulse", {press_tick, release_tick, short_tick, long_tick, repeat_tick}, '0);
            end
            check("db_level", db_level, m_lvl);
            check("is_long", is_long, m_long);
            if (press_tick != '0) last_press_vec = press_tick;
            for (int ch = 0; ch < N_CH; ch++) begin
                if (press_tick[ch])   begin obs_press[ch]++; press_cyc[ch] = edge_no; end
                if (release_tick[ch]) begin obs_rel[ch]++;   rel_cyc[ch]   = edge_no; end
                if (short_tick[ch])   obs_short[ch]++;
                if (long_tick[ch])    obs_long[ch]++;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int b_pr, b_rl, b_sh, b_lg, idx;
        // 1: reset with all buttons down, then a clean press on channel 0
        wait_clks(3);
        check("reset_outputs", {db_level, press_tick, release_tick, short_tick, long_tick, is_long, repeat_tick}, '0);
        reset = 1'b0;
        sw    = 4'b0001;
        b_pr  = obs_press[0];
        wait_clks(15);
        check("t1_press_count", obs_press[0] - b_pr, 1);
        check("t1_db_level0", db_level[0], 1'b1);

        // 2: one-sample bounces on channel 1
        b_pr = obs_press[1];
        for (int i = 0; i < 5; i++) begin
            sw[1] = 1'b1; wait_clks(TICK_DIV);
            sw[1] = 1'b0; wait_clks(TICK_DIV);
        end
        wait_clks(4 * TICK_DIV);
        check("t2_no_press", obs_press[1] - b_pr, 0);
        check("t2_db_level1", db_level[1], 1'b0);

        // 3: short press on channel 2
        b_pr = obs_press[2]; b_rl = obs_rel[2]; b_sh = obs_short[2]; b_lg = obs_long[2];
        sw[2] = 1'b1; wait_clks(6 * TICK_DIV);
        sw[2] = 1'b0; wait_clks(6 * TICK_DIV + 4);
        check("t3_press", obs_press[2] - b_pr, 1);
        check("t3_release", obs_rel[2] - b_rl, 1);
        check("t3_short", obs_short[2] - b_sh, 1);
        check("t3_long", obs_long[2] - b_lg, 0);

        // 4: long press on channel 3
        b_rl = obs_rel[3]; b_sh = obs_short[3]; b_lg = obs_long[3];
        sw[3] = 1'b1; wait_clks(20 * TICK_DIV);
        check("t4_long", obs_long[3] - b_lg, 1);
        check("t4_is_long_held", is_long[3], 1'b1);
        sw[3] = 1'b0; wait_clks(6 * TICK_DIV + 4);
        check("t4_release", obs_rel[3] - b_rl, 1);
        check("t4_short", obs_short[3] - b_sh, 0);
        check("t4_is_long_after", is_long[3], 1'b0);

        // 6: reset while channel 0 is confirming a release
        sw[0] = 1'b0; wait_clks(2 * TICK_DIV);
        check("t6_in_wait0", db_level[0], 1'b1);
        b_rl  = obs_rel[0];
        reset = 1'b1; wait_clks(1);
        check("t6_db_level_cleared", db_level, '0);
        reset = 1'b0; wait_clks(2);
        check("t6_no_release", obs_rel[0] - b_rl, 0);
        b_pr  = obs_press[0];
        sw[0] = 1'b1; wait_clks(5 * TICK_DIV);
        check("t6_repress", obs_press[0] - b_pr, 1);
        sw = '0; wait_clks(6 * TICK_DIV);

        // 5: simultaneous press, staggered release
        sw = 4'b0011; wait_clks(5 * TICK_DIV);
        check("t5_press_vec", last_press_vec, 4'b0011);
        check("t5_same_cycle", press_cyc[1] - press_cyc[0], 0);
        sw[0] = 1'b0; wait_clks(TICK_DIV);
        sw[1] = 1'b0; wait_clks(6 * TICK_DIV);
        check("t5_release_gap", rel_cyc[1] - rel_cyc[0], TICK_DIV);

        // Randomised phase: toggles, bounces, long holds and occasional resets
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1; wait_clks($urandom_range(1, 3));
                reset = 1'b0;
            end
            idx     = $urandom_range(0, N_CH - 1);
            sw[idx] = ~sw[idx];
            if ($urandom_range(0, 3) == 0) wait_clks($urandom_range(1, 6));
            else wait_clks($urandom_range(8, 80));
        end

        sw = '0; wait_clks(8 * TICK_DIV + 10);
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d)", checks);
        $fatal(1, "timeout");
    end
endmodule
